spi_slave16: RTL and testbench
==============================

Name: spi_slave16

Overview:
16-bit SPI responder: the far end of the team's 16-bit SPI master, used as the peripheral side on the bus (sensor/A2D model and on-chip register-port front end).
- Runs entirely in the clk domain; SCLK, SS_n and MOSI are treated as asynchronous and synchronized internally.
- Captures one MOSI word per frame and returns a parallel word on MISO.
- Flags completed frames with rdy and malformed frames with frm_err.

Parameters:
WIDTH, 16, frame length in bits (master issues 16-bit frames).
SYNC_STAGES, 2, synchronizer flops on SCLK/SS_n/MOSI (minimum 2).

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  synchronous reset, active-high
SCLK  input  1  SPI clock from master; idles high
SS_n  input  1  active-low slave select
MOSI  input  1  serial data from master, MSB first
MISO  output  1  serial data to master, MSB first
tx_data  input  WIDTH  word returned during the next frame
rx_data  output  WIDTH  last correctly received word
rdy  output  1  sticky; set on a good frame
clr_rdy  input  1  clears rdy
frm_err  output  1  sticky; set on a frame with bit count != WIDTH; cleared by clr_rdy
busy  output  1  high while a frame is in progress

Behaviour:
- Reset: all of the following take effect on the clk edge where rst=1:
  - rx_data=0, rdy=0, frm_err=0, busy=0, MISO=1.
  - tx shift register = all ones; bit_cnt=0; state=IDLE.
  - Synchronizer flops preset to 1 (SCLK/SS_n idle level).
- Synchronization:
  - SCLK, SS_n and MOSI each pass through SYNC_STAGES flops, followed by one history flop for edge detect.
  - Edges are therefore seen SYNC_STAGES+1 clks after the pin change.
  - Master SCLK half-period must be >= SYNC_STAGES+2 clks. The master's 16-clk half-period is compliant.
- SPI mode 3 (CPOL=1, CPHA=1):
  - Sample MOSI on SCLK rise.
  - Advance MISO on SCLK fall.
- States:
  - IDLE:
    - busy=0; MISO=1.
    - SS_n fall: load tx_data into tx shift reg, bit_cnt=0, go to SHIFT. The MSB appears on MISO the next clk.
    - SCLK edges are ignored while in IDLE.
  - SHIFT:
    - busy=1; MISO = tx_reg MSB.
    - SCLK rise: rx_reg <= {rx_reg[WIDTH-2:0], synchronized MOSI}; bit_cnt++. bit_cnt saturates at WIDTH+1.
    - SCLK fall with bit_cnt != 0: tx_reg <= {tx_reg[WIDTH-2:0], 1'b1}.
    - SCLK fall with bit_cnt == 0 (the leading edge before bit 0): tx_reg does not shift.
    - SS_n rise: go to DONE.
  - DONE (one clk):
    - If bit_cnt == WIDTH: rx_data <= rx_reg, rdy <= 1.
    - Otherwise: frm_err <= 1, and rx_data and rdy are unchanged.
    - Always return to IDLE.
- Latency: rdy is high on the clk after DONE, i.e. SYNC_STAGES+3 clks after the SS_n pin rise.
- Sticky flags:
  - rdy and frm_err hold until clr_rdy=1.
  - If clr_rdy and a DONE set occur in the same clk, the set wins.
- Back-to-back frames:
  - An SS_n fall while in DONE is still detected: the edge flag is held one clk, and IDLE consumes it.
  - rdy from the prior frame stays set until cleared.
- SS_n rise mid-word (short frame): frm_err, no rx_data update. tx_reg is reloaded at the next SS_n fall.
- rst asserted mid-frame: immediate return to IDLE on that clk. busy=0, MISO=1, and no rdy/frm_err.
- tx_data is sampled only at the SS_n fall; changes during a frame have no effect.

Test Plan:
- Nominal frame: tx_data=16'h3C5A; master sends cmd=16'hA5C3 with 16-clk SCLK half-period → rx_data=16'hA5C3, rdy=1 within 5 clks of SS_n rise, master rd_data=16'h3C5A, frm_err=0.
- Short frame: 8 SCLK cycles then SS_n high, with prior rx_data=16'hA5C3 → frm_err=1, rdy unchanged, rx_data=16'hA5C3.
- Long frame: 17 SCLK cycles → frm_err=1, rx_data unchanged; clr_rdy pulse → frm_err=0.
- Back-to-back frames: 16'h1234 then 16'hFEDC with SS_n high for 2 clks, clr_rdy never asserted → rdy stays 1, final rx_data=16'hFEDC, second MISO word = tx_data at second SS_n fall.
- Set vs clear: clr_rdy=1 on the same clk DONE completes a good frame → rdy=1 afterwards.
- Reset mid-frame: rst=1 after 6 bits → next clk busy=0, MISO=1; subsequent full frame 16'h0F0F received correctly with frm_err=0. SCLK toggling while SS_n high → no state change.

Source files
------------

// File: rtl/spi_slave16_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave16_if
// Purpose  : SPI pins plus parallel word/flag bus of the 16-bit SPI responder.
// Revision : 1.0  initial release
// ============================================================================
interface spi_slave16_if #(
    parameter int WIDTH = 16
);
    logic             SCLK;
    logic             SS_n;
    logic             MOSI;
    logic             MISO;
    logic [WIDTH-1:0] tx_data;
    logic [WIDTH-1:0] rx_data;
    logic             rdy;
    logic             clr_rdy;
    logic             frm_err;
    logic             busy;

    modport slave (
        input  SCLK, SS_n, MOSI, tx_data, clr_rdy,
        output MISO, rx_data, rdy, frm_err, busy
    );

    modport master (
        output SCLK, SS_n, MOSI, tx_data, clr_rdy,
        input  MISO, rx_data, rdy, frm_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave16.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave16
// Purpose  : SPI mode-3 responder, one WIDTH-bit word per SS_n frame, clk domain.
// Revision : 1.0  initial release
// ============================================================================
module spi_slave16 #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic    clk,
    input  wire logic    rst,
    spi_slave16_if.slave bus
);
    localparam int                 c_CNT_W    = $clog2(WIDTH + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // Bit SYNC_STAGES of the SCLK/SS_n chains is the edge-detect history flop.
    logic [SYNC_STAGES:0]   r_sclk_sync;
    logic [SYNC_STAGES:0]   r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    logic [WIDTH-1:0]   r_tx_shift;
    logic [WIDTH-1:0]   r_rx_shift;
    logic [WIDTH-1:0]   r_rx_data;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic               r_rdy;
    logic               r_frm_err;
    logic               r_ss_fall_pend;

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_fall;
    logic w_ss_rise;
    logic w_mosi;
    logic w_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '1;
            r_ss_sync   <= '1;
            r_mosi_sync <= '1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-1:0], bus.SCLK};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-1:0], bus.SS_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
        end
    end

    assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_sync[SYNC_STAGES];
    assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_sync[SYNC_STAGES];
    assign w_ss_fall   = ~r_ss_sync[SYNC_STAGES-1] & r_ss_sync[SYNC_STAGES];
    assign w_ss_rise   = r_ss_sync[SYNC_STAGES-1] & ~r_ss_sync[SYNC_STAGES];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    // A select edge arriving during DONE is remembered so IDLE can still start.
    assign w_start     = w_ss_fall | r_ss_fall_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_SHIFT;
            S_SHIFT: if (w_ss_rise) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_shift     <= '1;
            r_rx_shift     <= '0;
            r_rx_data      <= '0;
            r_bit_cnt      <= '0;
            r_rdy          <= 1'b0;
            r_frm_err      <= 1'b0;
            r_ss_fall_pend <= 1'b0;
        end else begin
            r_ss_fall_pend <= (r_state == S_DONE) && w_ss_fall;
            // Clear first so a same-cycle set from DONE overrides it.
            if (bus.clr_rdy) begin
                r_rdy     <= 1'b0;
                r_frm_err <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_tx_shift <= bus.tx_data;
                        r_bit_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (w_sclk_rise) begin
                        r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_mosi};
                        if (r_bit_cnt != c_CNT_SAT) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    if (w_sclk_fall && (r_bit_cnt != '0)) begin
                        r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b1};
                    end
                end
                S_DONE: begin
                    if (r_bit_cnt == c_CNT_FULL) begin
                        r_rx_data <= r_rx_shift;
                        r_rdy     <= 1'b1;
                    end else begin
                        r_frm_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.MISO    = (r_state == S_SHIFT) ? r_tx_shift[WIDTH-1] : 1'b1;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.rx_data = r_rx_data;
    assign bus.rdy     = r_rdy;
    assign bus.frm_err = r_frm_err;
endmodule
`default_nettype wire

// File: tb/tb_spi_slave16.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave16
// Purpose  : Mode-3 master driver, directed frame table and random frames for spi_slave16.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave16;
    localparam int WIDTH = 16;
    localparam int HALF  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    spi_slave16_if #(.WIDTH(WIDTH)) bus ();

    spi_slave16 #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] tx;
        logic [31:0] cmd;
        int          nbits;
        bit          clr_before;
        logic [15:0] exp_rx;
        bit          exp_rdy;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] rd;
    logic [31:0] rd2;
    logic [15:0] m_rx;
    bit          m_rdy;
    bit          m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected word seen by the master: tx MSB first, then ones once tx is exhausted.
    function automatic logic [31:0] exp_miso(input logic [15:0] tx, input int n);
        if (n <= 16) return 32'(tx) >> (16 - n);
        return (32'(tx) << (n - 16)) | ((32'd1 << (n - 16)) - 32'd1);
    endfunction

    task automatic pulse_clr();
        bus.clr_rdy = 1'b1;
        @(negedge clk);
        bus.clr_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic spi_frame(input logic [15:0] tx, input logic [31:0] cmd,
                             input int nbits, output logic [31:0] rdw);
        rdw         = '0;
        bus.tx_data = tx;
        bus.SS_n    = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.tx_data = 16'($urandom);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.SCLK = 1'b0;
            bus.MOSI = cmd[i];
            repeat (HALF) @(negedge clk);
            bus.SCLK = 1'b1;
            rdw      = {rdw[30:0], bus.MISO};
            repeat (HALF) @(negedge clk);
        end
        bus.SS_n = 1'b1;
    endtask

    task automatic model_frame(input logic [15:0] cmd, input int nbits);
        if (nbits == 16) begin
            m_rx  = cmd;
            m_rdy = 1'b1;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_rx"},  32'(bus.rx_data), 32'(m_rx));
        check({tag, "_rdy"}, 32'(bus.rdy),     32'(m_rdy));
        check({tag, "_err"}, 32'(bus.frm_err), 32'(m_err));
    endtask

    initial begin
        int lat;
        int prev_gap;
        bus.SCLK    = 1'b1;
        bus.SS_n    = 1'b1;
        bus.MOSI    = 1'b1;
        bus.tx_data = '0;
        bus.clr_rdy = 1'b0;

        vecs[0] = '{16'h3C5A, 32'hA5C3, 16, 1'b0, 16'hA5C3, 1'b1, 1'b0, 32'h0000_3C5A};
        vecs[1] = '{16'h1111, 32'h00FF,  8, 1'b0, 16'hA5C3, 1'b1, 1'b1, 32'h0000_0011};
        vecs[2] = '{16'h2222, 32'h0F0F, 17, 1'b1, 16'hA5C3, 1'b0, 1'b1, 32'h0000_4445};
        vecs[3] = '{16'h0000, 32'h0000,  0, 1'b1, 16'hA5C3, 1'b0, 1'b0, 32'h0000_0000};
        vecs[4] = '{16'hFFFF, 32'h0000, 16, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0000_FFFF};
        vecs[5] = '{16'h0000, 32'hFFFF, 16, 1'b0, 16'hFFFF, 1'b1, 1'b0, 32'h0000_0000};

        repeat (3) @(negedge clk);
        check("reset_rx",   32'(bus.rx_data), 32'h0);
        check("reset_rdy",  32'(bus.rdy),     32'h0);
        check("reset_err",  32'(bus.frm_err), 32'h0);
        check("reset_busy", 32'(bus.busy),    32'h0);
        check("reset_miso", 32'(bus.MISO),    32'h1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].clr_before) pulse_clr();
            if (vecs[i].nbits > 0) begin
                spi_frame(vecs[i].tx, vecs[i].cmd, vecs[i].nbits, rd);
                if (i == 0) begin
                    lat = 0;
                    for (int k = 1; k <= 6; k++) begin
                        @(negedge clk);
                        lat = k;
                        if (bus.rdy) break;
                    end
                    check("rdy_latency_ok", 32'(lat <= 5), 32'h1);
                end
                repeat (8) @(negedge clk);
                check($sformatf("vec%0d_miso", i), rd, vecs[i].exp_rd);
            end else begin
                repeat (2) @(negedge clk);
            end
            check($sformatf("vec%0d_rx", i),  32'(bus.rx_data), 32'(vecs[i].exp_rx));
            check($sformatf("vec%0d_rdy", i), 32'(bus.rdy),     32'(vecs[i].exp_rdy));
            check($sformatf("vec%0d_err", i), 32'(bus.frm_err), 32'(vecs[i].exp_err));
        end
        m_rx  = vecs[5].exp_rx;
        m_rdy = vecs[5].exp_rdy;
        m_err = vecs[5].exp_err;

        // Back-to-back frames with SS_n high for two clocks, rdy never cleared
        spi_frame(16'hAAAA, 32'h1234, 16, rd);
        model_frame(16'h1234, 16);
        repeat (2) @(negedge clk);
        spi_frame(16'h5555, 32'hFEDC, 16, rd2);
        model_frame(16'hFEDC, 16);
        repeat (8) @(negedge clk);
        check("b2b_miso1", rd,  32'h0000_AAAA);
        check("b2b_miso2", rd2, 32'h0000_5555);
        check_flags("b2b");

        // clr_rdy held high through the DONE cycle of a good frame
        spi_frame(16'h0000, 32'h1357, 16, rd);
        bus.clr_rdy = 1'b1;
        lat = 0;
        for (int k = 0; k < 20 && bus.busy; k++) begin
            @(negedge clk);
            lat = k + 1;
        end
        bus.clr_rdy = 1'b0;
        check("setclr_busy_dropped", 32'(bus.busy), 32'h0);
        m_rx  = 16'h1357;
        m_rdy = 1'b1;
        m_err = 1'b0;
        repeat (4) @(negedge clk);
        check_flags("setclr");

        // Reset in the middle of a frame
        bus.tx_data = 16'hABCD;
        bus.SS_n    = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            bus.SCLK = 1'b0;
            bus.MOSI = i[0];
            repeat (HALF) @(negedge clk);
            bus.SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        check("midrst_busy_before", 32'(bus.busy), 32'h1);
        rst      = 1'b1;
        bus.SS_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'h0);
        check("midrst_miso", 32'(bus.MISO), 32'h1);
        m_rx  = '0;
        m_rdy = 1'b0;
        m_err = 1'b0;
        repeat (8) @(negedge clk);
        check_flags("midrst");

        // SCLK activity while deselected must be ignored
        for (int i = 0; i < 8; i++) begin
            bus.SCLK = 1'b0;
            bus.MOSI = 1'b0;
            repeat (HALF) @(negedge clk);
            bus.SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        check("idle_sclk_busy", 32'(bus.busy), 32'h0);
        check("idle_sclk_miso", 32'(bus.MISO), 32'h1);
        check_flags("idle_sclk");

        spi_frame(16'h9669, 32'h0F0F, 16, rd);
        model_frame(16'h0F0F, 16);
        repeat (8) @(negedge clk);
        check("after_rst_miso", rd, 32'h0000_9669);
        check_flags("after_rst");

        // Randomized frames against the behavioural model
        prev_gap = 10;
        for (int it = 0; it < 24; it++) begin
            logic [15:0] tx;
            logic [15:0] cmd;
            int          nb;
            int          gap;
            tx  = 16'($urandom);
            cmd = 16'($urandom);
            nb  = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(1, 20));
            gap = int'($urandom_range(1, 10));
            if (prev_gap >= 8 && $urandom_range(0, 3) == 0) begin
                pulse_clr();
                m_rdy = 1'b0;
                m_err = 1'b0;
            end
            spi_frame(tx, {16'h0, cmd}, nb, rd);
            model_frame(cmd, nb);
            repeat (gap) @(negedge clk);
            check($sformatf("rnd%0d_miso", it), rd, exp_miso(tx, nb));
            if (gap >= 8) check_flags($sformatf("rnd%0d", it));
            prev_gap = gap;
        end
        repeat (8) @(negedge clk);
        check_flags("rnd_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
